control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/basic_computer_pkg.sv | 92 +++++++++
 rtl/control_unit_seq_counter.sv | 35 +++
 rtl/control_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_control_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/basic_computer_pkg.sv
// Shared encodings for the basic-computer control path: bus sources, ALU ops,
// opcodes, register-reference/IO bit positions and the decoded control word.
package basic_computer_pkg;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_TR   = 3'd6,
    BUS_MEM  = 3'd7
  } bus_sel_e;

  typedef enum logic [2:0] {
    ALU_AND     = 3'd0,
    ALU_ADD     = 3'd1,
    ALU_PASS_DR = 3'd2,
    ALU_CMA     = 3'd3,
    ALU_CIR     = 3'd4,
    ALU_CIL     = 3'd5
  } alu_sel_e;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_ADD    = 3'd1,
    OP_LDA    = 3'd2,
    OP_STA    = 3'd3,
    OP_BUN    = 3'd4,
    OP_BSA    = 3'd5,
    OP_ISZ    = 3'd6,
    OP_REG_IO = 3'd7
  } opcode_e;

  localparam int RR_CLA_BIT = 11;
  localparam int RR_CMA_BIT = 9;
  localparam int RR_CIR_BIT = 7;
  localparam int RR_CIL_BIT = 6;
  localparam int RR_INC_BIT = 5;
  localparam int RR_SPA_BIT = 4;
  localparam int RR_SNA_BIT = 3;
  localparam int RR_SZA_BIT = 2;
  localparam int RR_HLT_BIT = 0;
  localparam int IO_ION_BIT = 7;
  localparam int IO_IOF_BIT = 6;

  typedef enum logic [3:0] {
    RR_NONE, RR_HLT, RR_SZA, RR_SNA, RR_SPA, RR_INC, RR_CIL, RR_CIR, RR_CMA, RR_CLA
  } rr_op_e;

  typedef enum logic [1:0] {IO_NONE, IO_IOF, IO_ION} io_op_e;

  typedef struct packed {
    bus_sel_e s;
    alu_sel_e alu_sel;
    logic read_mem,  write_mem;
    logic reset_ir,  write_ir,  inc_ir;
    logic reset_dr,  write_dr,  inc_dr;
    logic reset_tr,  write_tr,  inc_tr;
    logic reset_ar,  write_ar,  inc_ar;
    logic reset_pc,  write_pc,  inc_pc;
    logic reset_ac,  write_ac,  inc_ac;
    logic reset_ien, write_ien;
    logic reset_r,   write_r;
  } ctrl_t;

  // Lowest-numbered implemented bit wins when several are set.
  function automatic rr_op_e decode_rr(input logic [11:0] bits);
    rr_op_e op;
    if      (bits[RR_HLT_BIT]) op = RR_HLT;
    else if (bits[RR_SZA_BIT]) op = RR_SZA;
    else if (bits[RR_SNA_BIT]) op = RR_SNA;
    else if (bits[RR_SPA_BIT]) op = RR_SPA;
    else if (bits[RR_INC_BIT]) op = RR_INC;
    else if (bits[RR_CIL_BIT]) op = RR_CIL;
    else if (bits[RR_CIR_BIT]) op = RR_CIR;
    else if (bits[RR_CMA_BIT]) op = RR_CMA;
    else if (bits[RR_CLA_BIT]) op = RR_CLA;
    else                       op = RR_NONE;
    return op;
  endfunction

  function automatic io_op_e decode_io(input logic [11:0] bits);
    io_op_e op;
    if      (bits[IO_IOF_BIT]) op = IO_IOF;
    else if (bits[IO_ION_BIT]) op = IO_ION;
    else                       op = IO_NONE;
    return op;
  endfunction

endpackage

// File: rtl/control_unit_seq_counter.sv
// 4-bit timing-step counter: counts every cycle, clears at instruction end,
// holds while the machine is halted, wraps 15->0.
module seq_counter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       hold,
  output logic [3:0] count
);

  logic [3:0] count_d;
  logic [3:0] count_q;

  // NOTE: every path assigns count_d via the default first, so no latch is inferred.
  always_comb begin
    count_d = count_q + 4'd1;
    if (hold) begin
      count_d = count_q;
    end else if (clr) begin
      count_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit for the basic computer: decodes T, IR, R and flags
// into combinational datapath strobes; sequencing lives in seq_counter.
module control_unit
  import basic_computer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] IR,
  input  logic [15:0] DR,
  input  logic        N,
  input  logic        Z,
  input  logic        IEN,
  input  logic        R,
  input  logic        intr_req,
  output logic [2:0]  S,
  output logic [2:0]  alu_SEL,
  output logic        readMEM,
  output logic        writeMEM,
  output logic        resetIR,
  output logic        writeIR,
  output logic        incIR,
  output logic        resetDR,
  output logic        writeDR,
  output logic        incDR,
  output logic        resetTR,
  output logic        writeTR,
  output logic        incTR,
  output logic        resetAR,
  output logic        writeAR,
  output logic        incAR,
  output logic        resetPC,
  output logic        writePC,
  output logic        incPC,
  output logic        resetAC,
  output logic        writeAC,
  output logic        incAC,
  output logic        resetIEN,
  output logic        writeIEN,
  output logic        resetR,
  output logic        writeR,
  output logic [3:0]  T,
  output logic        halted
);

  logic [3:0] t;
  logic       seq_clr;
  logic       i_d, i_q;
  logic       halted_d, halted_q;
  opcode_e    opcode;
  rr_op_e     rr_op;
  io_op_e     io_op;
  ctrl_t      ctrl;
  ctrl_t      ctrl_o;

  assign opcode = opcode_e'(IR[14:12]);
  assign rr_op  = decode_rr(IR[11:0]);
  assign io_op  = decode_io(IR[11:0]);

  seq_counter u_seq_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (seq_clr),
    .hold    (halted_q),
    .count   (t)
  );

  always_comb begin
    ctrl     = '0;
    seq_clr  = 1'b0;
    i_d      = i_q;
    halted_d = halted_q;
    if (!halted_q) begin
      case (t)
        4'd0: begin
          ctrl.s = BUS_PC;
          if (R) begin
            ctrl.reset_ar = 1'b1;
            ctrl.write_tr = 1'b1;
          end else begin
            ctrl.write_ar = 1'b1;
          end
        end
        4'd1: begin
          if (R) begin
            ctrl.s         = BUS_TR;
            ctrl.write_mem = 1'b1;
            ctrl.reset_pc  = 1'b1;
          end else begin
            ctrl.s        = BUS_MEM;
            ctrl.read_mem = 1'b1;
            ctrl.write_ir = 1'b1;
            ctrl.inc_pc   = 1'b1;
          end
        end
        4'd2: begin
          if (R) begin
            ctrl.inc_pc    = 1'b1;
            ctrl.reset_ien = 1'b1;
            ctrl.reset_r   = 1'b1;
            seq_clr        = 1'b1;
          end else begin
            ctrl.s        = BUS_IR;
            ctrl.write_ar = 1'b1;
            i_d           = IR[15];
          end
        end
        4'd3: begin
          if (opcode == OP_REG_IO) begin
            seq_clr = 1'b1;
            if (i_q) begin
              case (io_op)
                IO_ION:  ctrl.write_ien = 1'b1;
                IO_IOF:  ctrl.reset_ien = 1'b1;
                default: ;
              endcase
            end else begin
              case (rr_op)
                RR_HLT:  halted_d      = 1'b1;
                RR_SZA:  ctrl.inc_pc   = Z;
                RR_SNA:  ctrl.inc_pc   = N;
                RR_SPA:  ctrl.inc_pc   = ~N;
                RR_INC:  ctrl.inc_ac   = 1'b1;
                RR_CIL:  begin ctrl.alu_sel = ALU_CIL; ctrl.write_ac = 1'b1; end
                RR_CIR:  begin ctrl.alu_sel = ALU_CIR; ctrl.write_ac = 1'b1; end
                RR_CMA:  begin ctrl.alu_sel = ALU_CMA; ctrl.write_ac = 1'b1; end
                RR_CLA:  ctrl.reset_ac = 1'b1;
                default: ;
              endcase
            end
          end else if (i_q) begin
            ctrl.s        = BUS_MEM;
            ctrl.read_mem = 1'b1;
            ctrl.write_ar = 1'b1;
          end
        end
        4'd4: begin
          case (opcode)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              ctrl.s        = BUS_MEM;
              ctrl.read_mem = 1'b1;
              ctrl.write_dr = 1'b1;
            end
            OP_STA: begin
              ctrl.s         = BUS_AC;
              ctrl.write_mem = 1'b1;
              seq_clr        = 1'b1;
            end
            OP_BUN: begin
              ctrl.s        = BUS_AR;
              ctrl.write_pc = 1'b1;
              seq_clr       = 1'b1;
            end
            OP_BSA: begin
              ctrl.s         = BUS_PC;
              ctrl.write_mem = 1'b1;
              ctrl.inc_ar    = 1'b1;
            end
            default: ;
          endcase
        end
        4'd5: begin
          case (opcode)
            OP_AND:  begin ctrl.alu_sel = ALU_AND;     ctrl.write_ac = 1'b1; seq_clr = 1'b1; end
            OP_ADD:  begin ctrl.alu_sel = ALU_ADD;     ctrl.write_ac = 1'b1; seq_clr = 1'b1; end
            OP_LDA:  begin ctrl.alu_sel = ALU_PASS_DR; ctrl.write_ac = 1'b1; seq_clr = 1'b1; end
            OP_BSA:  begin ctrl.s = BUS_AR; ctrl.write_pc = 1'b1; seq_clr = 1'b1; end
            OP_ISZ:  ctrl.inc_dr = 1'b1;
            default: ;
          endcase
        end
        4'd6: begin
          if (opcode == OP_ISZ) begin
            ctrl.s         = BUS_DR;
            ctrl.write_mem = 1'b1;
            ctrl.inc_pc    = (DR == 16'h0000);
            seq_clr        = 1'b1;
          end
        end
        default: ;
      endcase
      // R only changes fetch decode, so a mid-instruction set waits for T0.
      if (intr_req && IEN && !R && t > 4'd2) begin
        ctrl.write_r = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_q      <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      i_q      <= i_d;
      halted_q <= halted_d;
    end
  end

  // Strobes are forced low for the whole reset window, not just after an edge.
  assign ctrl_o   = reset_n ? ctrl : '0;

  assign S        = ctrl_o.s;
  assign alu_SEL  = ctrl_o.alu_sel;
  assign readMEM  = ctrl_o.read_mem;
  assign writeMEM = ctrl_o.write_mem;
  assign resetIR  = ctrl_o.reset_ir;
  assign writeIR  = ctrl_o.write_ir;
  assign incIR    = ctrl_o.inc_ir;
  assign resetDR  = ctrl_o.reset_dr;
  assign writeDR  = ctrl_o.write_dr;
  assign incDR    = ctrl_o.inc_dr;
  assign resetTR  = ctrl_o.reset_tr;
  assign writeTR  = ctrl_o.write_tr;
  assign incTR    = ctrl_o.inc_tr;
  assign resetAR  = ctrl_o.reset_ar;
  assign writeAR  = ctrl_o.write_ar;
  assign incAR    = ctrl_o.inc_ar;
  assign resetPC  = ctrl_o.reset_pc;
  assign writePC  = ctrl_o.write_pc;
  assign incPC    = ctrl_o.inc_pc;
  assign resetAC  = ctrl_o.reset_ac;
  assign writeAC  = ctrl_o.write_ac;
  assign incAC    = ctrl_o.inc_ac;
  assign resetIEN = ctrl_o.reset_ien;
  assign writeIEN = ctrl_o.write_ien;
  assign resetR   = ctrl_o.reset_r;
  assign writeR   = ctrl_o.write_r;
  assign T        = t;
  assign halted   = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues the expected outputs of
// each cycle, a negedge monitor pops and compares.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] IR, DR;
  logic        N, Z, IEN, R, intr_req;
  logic [2:0]  S, alu_SEL;
  logic readMEM, writeMEM, resetIR, writeIR, incIR, resetDR, writeDR, incDR;
  logic resetTR, writeTR, incTR, resetAR, writeAR, incAR, resetPC, writePC, incPC;
  logic resetAC, writeAC, incAC, resetIEN, writeIEN, resetR, writeR;
  logic [3:0]  T;
  logic        halted;

  control_unit dut (
    .clk(clk), .reset_n(reset_n), .IR(IR), .DR(DR), .N(N), .Z(Z), .IEN(IEN), .R(R),
    .intr_req(intr_req), .S(S), .alu_SEL(alu_SEL), .readMEM(readMEM), .writeMEM(writeMEM),
    .resetIR(resetIR), .writeIR(writeIR), .incIR(incIR),
    .resetDR(resetDR), .writeDR(writeDR), .incDR(incDR),
    .resetTR(resetTR), .writeTR(writeTR), .incTR(incTR),
    .resetAR(resetAR), .writeAR(writeAR), .incAR(incAR),
    .resetPC(resetPC), .writePC(writePC), .incPC(incPC),
    .resetAC(resetAC), .writeAC(writeAC), .incAC(incAC),
    .resetIEN(resetIEN), .writeIEN(writeIEN), .resetR(resetR), .writeR(writeR),
    .T(T), .halted(halted)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] B_NONE = 3'd0, B_AR = 3'd1, B_PC = 3'd2, B_DR = 3'd3;
  localparam logic [2:0] B_AC = 3'd4, B_IR = 3'd5, B_TR = 3'd6, B_MEM = 3'd7;

  localparam logic [23:0] WRITE_R   = 24'h000001, RESET_R   = 24'h000002;
  localparam logic [23:0] WRITE_IEN = 24'h000004, RESET_IEN = 24'h000008;
  localparam logic [23:0] INC_AC    = 24'h000010, WRITE_AC  = 24'h000020, RESET_AC = 24'h000040;
  localparam logic [23:0] INC_PC    = 24'h000080, WRITE_PC  = 24'h000100, RESET_PC = 24'h000200;
  localparam logic [23:0] INC_AR    = 24'h000400, WRITE_AR  = 24'h000800, RESET_AR = 24'h001000;
  localparam logic [23:0] WRITE_TR  = 24'h004000, INC_DR    = 24'h010000, WRITE_DR = 24'h020000;
  localparam logic [23:0] WRITE_IR  = 24'h100000, WRITE_MEM = 24'h400000, READ_MEM = 24'h800000;

  logic [23:0] dut_strb;
  assign dut_strb = {readMEM, writeMEM, resetIR, writeIR, incIR, resetDR, writeDR, incDR,
                     resetTR, writeTR, incTR, resetAR, writeAR, incAR, resetPC, writePC, incPC,
                     resetAC, writeAC, incAC, resetIEN, writeIEN, resetR, writeR};

  typedef struct packed {
    logic [3:0]  t;
    logic [2:0]  s;
    logic [23:0] strb;
    logic [2:0]  alu;
    logic        alu_chk;
    logic        halted;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (T !== e.t || S !== e.s || dut_strb !== e.strb || halted !== e.halted ||
          (e.alu_chk && alu_SEL !== e.alu)) begin
        n_fail++;
        $display("FAIL %s: got T=%0d S=%0d strb=%h alu=%0d halted=%b, expected T=%0d S=%0d strb=%h alu=%0d(chk=%0b) halted=%b",
                 nm, T, S, dut_strb, alu_SEL, halted, e.t, e.s, e.strb, e.alu, e.alu_chk, e.halted);
      end
    end
  end

  // Advance to just after the next rising edge and queue that cycle's expectation;
  // inputs assigned right after the call still apply before the negedge sample.
  task automatic cyc(input string nm, input logic [3:0] t, input logic [2:0] s,
                     input logic [23:0] st, input logic [2:0] alu, input bit alu_chk,
                     input logic h);
    exp_t e;
    @(posedge clk);
    #1;
    e.t = t; e.s = s; e.strb = st; e.alu = alu; e.alu_chk = alu_chk; e.halted = h;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic fetch(input string nm, input logic [15:0] ir, input bit release_rst);
    cyc({nm, " T0"}, 4'd0, B_PC, WRITE_AR, 3'd0, 1'b0, 1'b0);
    if (release_rst) reset_n = 1'b1;
    IR = ir;
    cyc({nm, " T1"}, 4'd1, B_MEM, READ_MEM | WRITE_IR | INC_PC, 3'd0, 1'b0, 1'b0);
    cyc({nm, " T2"}, 4'd2, B_IR, WRITE_AR, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic regref(input string nm, input logic [15:0] ir, input logic n_in,
                        input logic z_in, input logic [23:0] st, input logic [2:0] alu,
                        input bit alu_chk);
    fetch(nm, ir, 1'b0);
    N = n_in;
    Z = z_in;
    cyc({nm, " T3"}, 4'd3, B_NONE, st, alu, alu_chk, 1'b0);
  endtask

  task automatic isz(input string nm, input logic [15:0] dr_t5, input logic [15:0] dr_t6,
                     input logic [23:0] st_t6);
    fetch(nm, 16'h6010, 1'b0);
    cyc({nm, " T3"}, 4'd3, B_NONE, 24'h0, 3'd0, 1'b0, 1'b0);
    cyc({nm, " T4"}, 4'd4, B_MEM, READ_MEM | WRITE_DR, 3'd0, 1'b0, 1'b0);
    cyc({nm, " T5"}, 4'd5, B_NONE, INC_DR, 3'd0, 1'b0, 1'b0);
    DR = dr_t5;
    cyc({nm, " T6"}, 4'd6, B_DR, st_t6, 3'd0, 1'b0, 1'b0);
    DR = dr_t6;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; IR = 16'h0000; DR = 16'h0000;
    N = 1'b0; Z = 1'b0; IEN = 1'b0; R = 1'b0; intr_req = 1'b0;

    cyc("reset0", 4'd0, B_NONE, 24'h0, 3'd0, 1'b1, 1'b0);
    cyc("reset1", 4'd0, B_NONE, 24'h0, 3'd0, 1'b1, 1'b0);

    // LDA direct
    fetch("lda", 16'h2005, 1'b1);
    cyc("lda T3", 4'd3, B_NONE, 24'h0, 3'd0, 1'b0, 1'b0);
    cyc("lda T4", 4'd4, B_MEM, READ_MEM | WRITE_DR, 3'd0, 1'b0, 1'b0);
    cyc("lda T5", 4'd5, B_NONE, WRITE_AC, 3'd2, 1'b1, 1'b0);

    // AND indirect
    fetch("and_ind", 16'h8123, 1'b0);
    cyc("and_ind T3", 4'd3, B_MEM, READ_MEM | WRITE_AR, 3'd0, 1'b0, 1'b0);
    cyc("and_ind T4", 4'd4, B_MEM, READ_MEM | WRITE_DR, 3'd0, 1'b0, 1'b0);
    cyc("and_ind T5", 4'd5, B_NONE, WRITE_AC, 3'd0, 1'b1, 1'b0);

    // ISZ: skip only when the incremented word is zero
    isz("isz_ffff", 16'hFFFF, 16'h0000, WRITE_MEM | INC_PC);
    isz("isz_0003", 16'h0003, 16'h0004, WRITE_MEM);

    fetch("sta", 16'h3010, 1'b0);
    cyc("sta T3", 4'd3, B_NONE, 24'h0, 3'd0, 1'b0, 1'b0);
    cyc("sta T4", 4'd4, B_AC, WRITE_MEM, 3'd0, 1'b0, 1'b0);

    fetch("bun", 16'h4020, 1'b0);
    cyc("bun T3", 4'd3, B_NONE, 24'h0, 3'd0, 1'b0, 1'b0);
    cyc("bun T4", 4'd4, B_AR, WRITE_PC, 3'd0, 1'b0, 1'b0);

    fetch("bsa", 16'h5030, 1'b0);
    cyc("bsa T3", 4'd3, B_NONE, 24'h0, 3'd0, 1'b0, 1'b0);
    cyc("bsa T4", 4'd4, B_PC, WRITE_MEM | INC_AR, 3'd0, 1'b0, 1'b0);
    cyc("bsa T5", 4'd5, B_AR, WRITE_PC, 3'd0, 1'b0, 1'b0);

    // Register-reference and IO words
    regref("spa_n1",  16'h7010, 1'b1, 1'b0, 24'h0,     3'd0, 1'b0);
    regref("spa_n0",  16'h7010, 1'b0, 1'b0, INC_PC,    3'd0, 1'b0);
    regref("sna_n1",  16'h7008, 1'b1, 1'b0, INC_PC,    3'd0, 1'b0);
    regref("sza_z1",  16'h7004, 1'b0, 1'b1, INC_PC,    3'd0, 1'b0);
    regref("sza_z0",  16'h7004, 1'b0, 1'b0, 24'h0,     3'd0, 1'b0);
    regref("cla",     16'h7800, 1'b0, 1'b0, RESET_AC,  3'd0, 1'b0);
    regref("cla_cma", 16'h7A00, 1'b0, 1'b0, WRITE_AC,  3'd3, 1'b1);
    regref("cir",     16'h7080, 1'b0, 1'b0, WRITE_AC,  3'd4, 1'b1);
    regref("cil",     16'h7040, 1'b0, 1'b0, WRITE_AC,  3'd5, 1'b1);
    regref("inc",     16'h7020, 1'b0, 1'b0, INC_AC,    3'd0, 1'b0);
    regref("ion",     16'hF080, 1'b0, 1'b0, WRITE_IEN, 3'd0, 1'b0);
    regref("iof",     16'hF040, 1'b0, 1'b0, RESET_IEN, 3'd0, 1'b0);

    // Interrupt raised at T4 of ADD; R is driven as the datapath flag would be
    IEN = 1'b1;
    fetch("add_int", 16'h1000, 1'b0);
    cyc("add_int T3", 4'd3, B_NONE, 24'h0, 3'd0, 1'b0, 1'b0);
    cyc("add_int T4", 4'd4, B_MEM, READ_MEM | WRITE_DR | WRITE_R, 3'd0, 1'b0, 1'b0);
    intr_req = 1'b1;
    cyc("add_int T5", 4'd5, B_NONE, WRITE_AC, 3'd1, 1'b1, 1'b0);
    R = 1'b1;
    cyc("int RT0", 4'd0, B_PC, RESET_AR | WRITE_TR, 3'd0, 1'b0, 1'b0);
    cyc("int RT1", 4'd1, B_TR, WRITE_MEM | RESET_PC, 3'd0, 1'b0, 1'b0);
    cyc("int RT2", 4'd2, B_NONE, INC_PC | RESET_IEN | RESET_R, 3'd0, 1'b0, 1'b0);

    // HLT with INC also set; request still pending so T3 sets R again
    cyc("hlt T0", 4'd0, B_PC, WRITE_AR, 3'd0, 1'b0, 1'b0);
    R = 1'b0;
    IR = 16'h7021;
    cyc("hlt T1", 4'd1, B_MEM, READ_MEM | WRITE_IR | INC_PC, 3'd0, 1'b0, 1'b0);
    cyc("hlt T2", 4'd2, B_IR, WRITE_AR, 3'd0, 1'b0, 1'b0);
    cyc("hlt T3", 4'd3, B_NONE, WRITE_R, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc("halted", 4'd0, B_NONE, 24'h0, 3'd0, 1'b1, 1'b1);
      R = 1'b1;
    end
    cyc("hlt_reset", 4'd0, B_NONE, 24'h0, 3'd0, 1'b1, 1'b0);
    reset_n = 1'b0; R = 1'b0; IEN = 1'b0; intr_req = 1'b0;

    // Reset dropped in the middle of ADD at T5
    fetch("add_rst", 16'h1000, 1'b1);
    cyc("add_rst T3", 4'd3, B_NONE, 24'h0, 3'd0, 1'b0, 1'b0);
    cyc("add_rst T4", 4'd4, B_MEM, READ_MEM | WRITE_DR, 3'd0, 1'b0, 1'b0);
    cyc("add_rst T5 in reset", 4'd0, B_NONE, 24'h0, 3'd0, 1'b1, 1'b0);
    reset_n = 1'b0;
    cyc("add_rst hold", 4'd0, B_NONE, 24'h0, 3'd0, 1'b1, 1'b0);
    fetch("post_rst", 16'h2005, 1'b1);
    cyc("post_rst T3", 4'd3, B_NONE, 24'h0, 3'd0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
